control_sequencer: RTL and testbench

- Hardwired Moore control unit for the single-bus CPU datapath.
- Replaces the hand-driven control-signal sequences used during datapath bring-up. It generates the T0..T6 fetch/execute control strobes from the IR contents.
- Covers the register-register ALU class, mul/div, unary ops, nop and halt.
- Register selection uses select-and-encode outputs: Gra/Grb/Grc together with Rin/Rout.

---
 rtl/control_sequencer.sv | 219 +++++++++++++++++++++
 tb/tb_control_sequencer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// ---------------------------------------------------------------------------
// control_sequencer
//   Hardwired Moore control unit for the single-bus CPU datapath. It walks
//   the T0..T6 fetch/execute steps and raises the control strobes for the
//   register-register ALU class, mul/div, unary ops (neg/not), nop and halt.
//
// Ports
//   Clock     in   rising-edge system clock
//   Clear     in   asynchronous active-high reset (aborts any instruction)
//   IR        in   instruction register; opcode IR[31:27]
//   MemReady  in   memory read-data-valid, sampled in T1
//   PCout, ZHighout, Zlowout, MDRout        out  bus drive enables
//   MARin, PCin, MDRin, IRin, Yin           out  register load enables
//   ZLowIn, ZHighIn, HIin, LOin             out  register load enables
//   IncPC, Read                             out  PC increment, memory read
//   Gra, Grb, Grc, Rin, Rout                out  select-and-encode controls
//   alu_op    out  ALU function select (opcode value in T4, else 0)
//   Run       out  1 while executing, 0 in reset or halt
// ---------------------------------------------------------------------------
module control_sequencer #(
   parameter int             OPW     = 5,
   parameter logic [OPW-1:0] HALT_OP = 5'b11011,
   parameter logic [OPW-1:0] NOP_OP  = 5'b11000
) (
   input  logic           Clock,
   input  logic           Clear,
   input  logic [31:0]    IR,
   input  logic           MemReady,
   output logic           PCout,
   output logic           ZHighout,
   output logic           Zlowout,
   output logic           MDRout,
   output logic           MARin,
   output logic           PCin,
   output logic           MDRin,
   output logic           IRin,
   output logic           Yin,
   output logic           ZLowIn,
   output logic           ZHighIn,
   output logic           HIin,
   output logic           LOin,
   output logic           IncPC,
   output logic           Read,
   output logic           Gra,
   output logic           Grb,
   output logic           Grc,
   output logic           Rin,
   output logic           Rout,
   output logic [OPW-1:0] alu_op,
   output logic           Run
);

   typedef enum logic [3:0] {
      S_RST  = 4'd0,
      S_T0   = 4'd1,
      S_T1   = 4'd2,
      S_T2   = 4'd3,
      S_T3   = 4'd4,
      S_T4   = 4'd5,
      S_T5   = 4'd6,
      S_T6   = 4'd7,
      S_HALT = 4'd8
   } state_t;

   state_t         state_r;
   state_t         state_nxt_s;
   logic [OPW-1:0] op_r;
   logic [OPW-1:0] opcode_s;
   logic           unused_ir_s;

   // Two-operand ALU ops: second operand comes from Rc.
   function automatic logic is_binary(input logic [OPW-1:0] op);
      case (op)
         5'b00011, 5'b00100, 5'b00101, 5'b00110,
         5'b00111, 5'b01000, 5'b01001, 5'b01010, 5'b01011: is_binary = 1'b1;
         default:                                           is_binary = 1'b0;
      endcase
   endfunction

   // Unary ops (neg/not): operand comes from Rb.
   function automatic logic is_unary(input logic [OPW-1:0] op);
      case (op)
         5'b10001, 5'b10010: is_unary = 1'b1;
         default:            is_unary = 1'b0;
      endcase
   endfunction

   // mul/div: 64-bit result split over LO (T5) and HI (T6).
   function automatic logic is_muldiv(input logic [OPW-1:0] op);
      case (op)
         5'b01111, 5'b10000: is_muldiv = 1'b1;
         default:            is_muldiv = 1'b0;
      endcase
   endfunction

   assign opcode_s = IR[31 -: OPW];
   // Register fields are consumed by the datapath's select-and-encode logic.
   assign unused_ir_s = ^IR[31-OPW:0];

   // State register.
   always_ff @(posedge Clock or posedge Clear) begin
      if (Clear) begin
         state_r <= S_RST;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Opcode snapshot taken in T3 so T4..T6 do not depend on IR staying put.
   always_ff @(posedge Clock or posedge Clear) begin
      if (Clear) begin
         op_r <= '0;
      end else if (state_r == S_T3) begin
         op_r <= opcode_s;
      end else begin
         op_r <= op_r;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         S_RST: state_nxt_s = S_T0;
         S_T0:  state_nxt_s = S_T1;
         S_T1:  state_nxt_s = MemReady ? S_T2 : S_T1;
         S_T2:  state_nxt_s = S_T3;
         // IR is first valid here, one cycle after IRin.
         S_T3: begin
            if (opcode_s == HALT_OP) begin
               state_nxt_s = S_HALT;
            end else if (is_binary(opcode_s) || is_unary(opcode_s) ||
                         is_muldiv(opcode_s)) begin
               state_nxt_s = S_T4;
            end else begin
               state_nxt_s = S_T0;  // nop and undefined opcodes: fetch only
            end
         end
         S_T4:   state_nxt_s = S_T5;
         S_T5:   state_nxt_s = is_muldiv(op_r) ? S_T6 : S_T0;
         S_T6:   state_nxt_s = S_T0;
         S_HALT: state_nxt_s = S_HALT;
         default: state_nxt_s = S_RST;
      endcase
   end

   // Moore output decode.
   always_comb begin
      PCout    = 1'b0;
      ZHighout = 1'b0;
      Zlowout  = 1'b0;
      MDRout   = 1'b0;
      MARin    = 1'b0;
      PCin     = 1'b0;
      MDRin    = 1'b0;
      IRin     = 1'b0;
      Yin      = 1'b0;
      ZLowIn   = 1'b0;
      ZHighIn  = 1'b0;
      HIin     = 1'b0;
      LOin     = 1'b0;
      IncPC    = 1'b0;
      Read     = 1'b0;
      Gra      = 1'b0;
      Grb      = 1'b0;
      Grc      = 1'b0;
      Rin      = 1'b0;
      Rout     = 1'b0;
      alu_op   = '0;
      Run      = (state_r != S_RST) && (state_r != S_HALT);
      case (state_r)
         S_T0: begin
            PCout  = 1'b1;
            MARin  = 1'b1;
            IncPC  = 1'b1;
            ZLowIn = 1'b1;
         end
         // Strobes stay up for the whole memory wait.
         S_T1: begin
            Zlowout = 1'b1;
            PCin    = 1'b1;
            Read    = 1'b1;
            MDRin   = 1'b1;
         end
         S_T2: begin
            MDRout = 1'b1;
            IRin   = 1'b1;
         end
         // Load Y from Rb for executable opcodes; nop/undef/halt stay quiet.
         S_T3: begin
            Grb  = is_binary(opcode_s) || is_unary(opcode_s) || is_muldiv(opcode_s);
            Rout = Grb;
            Yin  = Grb;
         end
         S_T4: begin
            Rout    = 1'b1;
            ZLowIn  = 1'b1;
            alu_op  = op_r;
            Grb     = is_unary(op_r);
            Grc     = !is_unary(op_r);
            ZHighIn = is_muldiv(op_r);
         end
         S_T5: begin
            Zlowout = 1'b1;
            Gra     = !is_muldiv(op_r);
            Rin     = !is_muldiv(op_r);
            LOin    = is_muldiv(op_r);
         end
         S_T6: begin
            ZHighout = 1'b1;
            HIin     = 1'b1;
         end
         default: begin
            Run = Run;  // RST and HALT: every strobe stays at its default 0
         end
      endcase
   end

endmodule

// File: tb/tb_control_sequencer.sv
// ---------------------------------------------------------------------------
// tb_control_sequencer
//   Scoreboard bench: each driven cycle pushes its expected output vector,
//   a negedge monitor pops and compares. A small IR register model loads the
//   instruction on IRin, and a negedge monitor checks the bus invariants.
// ---------------------------------------------------------------------------
module tb_control_sequencer;

   logic        Clock = 1'b0;
   logic        Clear;
   logic [31:0] IR;
   logic        MemReady;
   logic PCout, ZHighout, Zlowout, MDRout, MARin, PCin, MDRin, IRin, Yin;
   logic ZLowIn, ZHighIn, HIin, LOin, IncPC, Read;
   logic Gra, Grb, Grc, Rin, Rout, Run;
   logic [4:0] alu_op;

   typedef struct packed {
      logic PCout, ZHighout, Zlowout, MDRout, MARin, PCin, MDRin, IRin, Yin;
      logic ZLowIn, ZHighIn, HIin, LOin, IncPC, Read;
      logic Gra, Grb, Grc, Rin, Rout;
      logic [4:0] alu_op;
      logic Run;
   } outs_t;

   outs_t       got_s;
   outs_t       exp_q[$];
   string       tag_q[$];
   logic [31:0] next_instr;
   logic [31:0] ir_q = 32'h0000_0000;
   int          errors = 0;
   int          checks = 0;

   control_sequencer dut (
      .Clock(Clock), .Clear(Clear), .IR(IR), .MemReady(MemReady),
      .PCout(PCout), .ZHighout(ZHighout), .Zlowout(Zlowout), .MDRout(MDRout),
      .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
      .ZLowIn(ZLowIn), .ZHighIn(ZHighIn), .HIin(HIin), .LOin(LOin),
      .IncPC(IncPC), .Read(Read), .Gra(Gra), .Grb(Grb), .Grc(Grc),
      .Rin(Rin), .Rout(Rout), .alu_op(alu_op), .Run(Run)
   );

   always #5 Clock = ~Clock;

   assign got_s = {PCout, ZHighout, Zlowout, MDRout, MARin, PCin, MDRin, IRin, Yin,
                   ZLowIn, ZHighIn, HIin, LOin, IncPC, Read,
                   Gra, Grb, Grc, Rin, Rout, alu_op, Run};
   assign IR = ir_q;

   // Instruction register as the datapath would load it from MDR.
   always @(posedge Clock) begin
      if (IRin) ir_q <= next_instr;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Scoreboard consumer.
   always @(negedge Clock) begin
      if (exp_q.size() > 0) begin
         outs_t e;
         string t;
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         check_eq(t, {6'd0, got_s}, {6'd0, e});
      end
   end

   // Invariant monitor.
   always @(negedge Clock) begin
      check_eq("bus_drivers", (int'(PCout) + int'(ZHighout) + int'(Zlowout) +
                               int'(MDRout) + int'(Rout)) <= 1, 32'd1);
      if (Rin || Rout)
         check_eq("gsel_onehot", int'(Gra) + int'(Grb) + int'(Grc), 32'd1);
   end

   // ---- expected vectors ----
   function automatic outs_t e_zero(input logic run);
      outs_t o;
      o = '0;
      o.Run = run;
      return o;
   endfunction
   function automatic outs_t e_t0();
      outs_t o;
      o = e_zero(1'b1);
      o.PCout = 1'b1; o.MARin = 1'b1; o.IncPC = 1'b1; o.ZLowIn = 1'b1;
      return o;
   endfunction
   function automatic outs_t e_t1();
      outs_t o;
      o = e_zero(1'b1);
      o.Zlowout = 1'b1; o.PCin = 1'b1; o.Read = 1'b1; o.MDRin = 1'b1;
      return o;
   endfunction
   function automatic outs_t e_t2();
      outs_t o;
      o = e_zero(1'b1);
      o.MDRout = 1'b1; o.IRin = 1'b1;
      return o;
   endfunction
   function automatic outs_t e_t3();
      outs_t o;
      o = e_zero(1'b1);
      o.Grb = 1'b1; o.Rout = 1'b1; o.Yin = 1'b1;
      return o;
   endfunction
   function automatic outs_t e_t4(input logic [4:0] op, input logic un, input logic md);
      outs_t o;
      o = e_zero(1'b1);
      o.Rout = 1'b1; o.ZLowIn = 1'b1; o.alu_op = op;
      if (un) o.Grb = 1'b1; else o.Grc = 1'b1;
      o.ZHighIn = md;
      return o;
   endfunction
   function automatic outs_t e_t5(input logic md);
      outs_t o;
      o = e_zero(1'b1);
      o.Zlowout = 1'b1;
      if (md) o.LOin = 1'b1;
      else begin o.Gra = 1'b1; o.Rin = 1'b1; end
      return o;
   endfunction
   function automatic outs_t e_t6();
      outs_t o;
      o = e_zero(1'b1);
      o.ZHighout = 1'b1; o.HIin = 1'b1;
      return o;
   endfunction

   // One clock cycle: drive MemReady, push the expectation, advance.
   task automatic step(input outs_t e, input logic mr, input string tag);
      MemReady = mr;
      exp_q.push_back(e);
      tag_q.push_back(tag);
      @(posedge Clock);
      #1;
   endtask

   task automatic do_reset(input int n);
      Clear = 1'b1;
      for (int i = 0; i < n; i++) step(e_zero(1'b0), 1'b1, "reset");
      Clear = 1'b0;
      step(e_zero(1'b0), 1'b1, "reset_release");
   endtask

   // Fetch T0..T2 with w memory wait cycles, then the execute part unless
   // exec_steps limits it (used for the mid-instruction abort).
   task automatic run_instr(input logic [31:0] instr, input int w, input string name,
                            input int exec_steps);
      logic [4:0] op;
      logic bin, un, md;
      op  = instr[31:27];
      bin = (op >= 5'd3) && (op <= 5'd11);
      un  = (op == 5'd17) || (op == 5'd18);
      md  = (op == 5'd15) || (op == 5'd16);
      next_instr = instr;
      step(e_t0(), 1'b1, {name, "_T0"});
      for (int i = 0; i < w; i++) step(e_t1(), 1'b0, {name, "_T1wait"});
      step(e_t1(), 1'b1, {name, "_T1"});
      step(e_t2(), 1'b1, {name, "_T2"});
      if (bin || un || md) begin
         step(e_t3(), 1'b1, {name, "_T3"});
         if (exec_steps > 1) step(e_t4(op, un, md), 1'b1, {name, "_T4"});
         if (exec_steps > 2) step(e_t5(md), 1'b1, {name, "_T5"});
         if (exec_steps > 3 && md) step(e_t6(), 1'b1, {name, "_T6"});
      end else begin
         step(e_zero(1'b1), 1'b1, {name, "_T3"});
      end
   endtask

   initial begin
      Clear      = 1'b1;
      MemReady   = 1'b1;
      next_instr = 32'h0000_0000;
      @(posedge Clock);
      #1;
      do_reset(2);

      run_instr(32'h4A92_0000, 0, "shr",  4);
      run_instr(32'h18A2_0000, 3, "add_wait", 4);
      run_instr(32'h78A2_0000, 0, "mul",  4);
      run_instr(32'h80A2_0000, 0, "div",  4);
      run_instr(32'h88A0_0000, 0, "neg",  4);
      run_instr(32'h90A0_0000, 0, "not",  4);
      run_instr(32'hC000_0000, 0, "nop",  4);
      run_instr(32'hF800_0000, 0, "undef", 4);
      run_instr(32'h20A2_0000, 1, "sub",  4);
      // add aborted right after entering T4: outputs drop at once, no Rin.
      run_instr(32'h18A2_0000, 0, "add_abort", 1);
      do_reset(2);
      run_instr(32'h40A2_0000, 2, "rol",  4);
      run_instr(32'hD800_0000, 0, "halt", 4);
      for (int i = 0; i < 20; i++) step(e_zero(1'b0), 1'b1, "halted");
      do_reset(1);
      run_instr(32'h28A2_0000, 0, "and",  4);
      run_instr(32'h5800_0000, 0, "shl",  4);

      check_eq("queue_drained", exp_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
